mem_data_seq: RTL and testbench
===============================

MEM_DATA_SEQ -- requirements
Module: mem_data_seq

Interface
REQ-001 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous active-low reset; 0 = reset.
- i_id_mem_op  in  2  ID-stage op: 0 none, 1 load, 2 store, 3 reserved (treated as none).
- i_id_size  in  2  ID-stage size: 0 byte, 1 half, 2 word, 3 reserved (treated as word).
- o_mem_data_access  out  4  ID-stage cycle count for the stall controller.
- i_mem_req  in  1  MEM-stage request strobe.
- i_mem_we  in  1  MEM-stage write enable: 1 store, 0 load.
- i_mem_size  in  2  MEM-stage size, same encoding as i_id_size.
- i_mem_unsigned  in  1  load extension: 1 zero-extend, 0 sign-extend.
- i_mem_addr  in  32  MEM-stage byte address.
- i_mem_wdata  in  32  MEM-stage store data.
- o_mem_rdata  out  32  load result, extended to 32 bits.
- o_mem_done  out  1  one-cycle completion pulse.
- o_mem_misalign  out  1  one-cycle misalignment flag, coincident with o_mem_done.
- o_mem_busy  out  1  high while a request is in progress.
- o_bus_en  out  1  byte-bus cycle enable.
- o_bus_we  out  1  byte-bus write.
- o_bus_addr  out  32  byte-bus address.
- o_bus_wdata  out  8  byte-bus write data.
- i_bus_rdata  in  8  byte-bus read data; valid 1 cycle after a read cycle.

Function
REQ-002 o_mem_data_access SHALL be combinational from the ID inputs: 0 for no op; otherwise N+1, where N = 1 for byte, 2 for half, 4 for word.
REQ-003 The FSM SHALL have three states: IDLE, XFER and DONE.
REQ-004 In IDLE, with i_mem_req=1 and the address aligned, the block SHALL latch we, size, unsigned, addr and wdata, set beat=0, and enter XFER.
REQ-005 Alignment rule: a half access needs addr[0]=0; a word access needs addr[1:0]=0; a byte access is always aligned.
REQ-006 A misaligned request SHALL go IDLE->DONE, issue no bus cycle, and assert o_mem_misalign with o_mem_done; o_mem_rdata SHALL keep its previous value.
REQ-007 In XFER, the block SHALL drive o_bus_en=1 on each of N consecutive cycles, with o_bus_addr = latched addr + beat and byte order little-endian.
REQ-008 For stores, o_bus_wdata SHALL be wdata byte[beat]; for loads, o_bus_wdata SHALL be 0.
REQ-009 After beat N-1 the FSM SHALL enter DONE.
REQ-010 Loads: i_bus_rdata SHALL be captured into byte lane beat-1 on the cycle after each read beat; the last byte SHALL be captured on entry to DONE.
REQ-011 In DONE, o_mem_done SHALL be 1 for exactly one cycle with o_mem_rdata valid, and the FSM SHALL return to IDLE.
REQ-012 Total request-to-done latency SHALL be N+1 cycles, matching o_mem_data_access.
REQ-013 Load extension: byte/half results SHALL be sign- or zero-extended per latched unsigned; word results SHALL pass through unchanged.
REQ-014 o_mem_busy SHALL be 1 in XFER and in DONE.
REQ-015 i_mem_req received while not in IDLE SHALL be ignored; there is no queueing.
REQ-016 o_bus_en SHALL be 0 outside XFER; o_bus_we SHALL equal latched we during XFER and be 0 otherwise.
REQ-017 Beat counter width SHALL be 3 bits; beat SHALL never exceed N-1 and there is no wrap.

Reset
REQ-018 On rst=0, the following SHALL clear immediately and asynchronously: state=IDLE, o_mem_done=0, o_mem_misalign=0, o_mem_busy=0, o_bus_en=0, o_bus_we=0, o_bus_addr=0, o_bus_wdata=0, o_mem_rdata=0, beat=0.
REQ-019 Reset mid-XFER SHALL abort the transfer with no further bus cycle and no o_mem_done pulse.
REQ-020 The first request SHALL be accepted on the first rising clk edge after rst deasserts.

Structure
REQ-021 A shared package mem_pkg SHALL hold the op encodings (NONE, LOAD, STORE), size encodings (BYTE, HALF, WORD), the size-to-beat-count function, and BUS_W=8.
REQ-022 Sub-module mem_rdata_ext SHALL be a combinational extender (size, unsigned, raw 32-bit) -> 32-bit result, instantiated once.

Verification
REQ-023 ID op=load, size=word -> o_mem_data_access=5; op=none -> 0; byte store -> 2.
REQ-024 Word load at 0x100 with bus bytes 0x11,0x22,0x33,0x44 -> bus addrs 0x100..0x103, o_mem_done 5 cycles after req, o_mem_rdata=0x44332211.
REQ-025 Byte load at 0x203, i_bus_rdata=0x80, unsigned=0 -> o_mem_rdata=0xFFFFFF80; same with unsigned=1 -> 0x00000080.
REQ-026 Half store 0xBEEF at 0x10 -> bus writes 0xEF@0x10 then 0xBE@0x11, o_mem_done at cycle 3.
REQ-027 Word request at 0x102 -> no o_bus_en, o_mem_done and o_mem_misalign pulse on the next cycle.
REQ-028 rst low during beat 2 of a word store -> o_bus_en falls immediately, no o_mem_done; a new byte load after release completes in 2 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings, request bundle and size helpers
// for the byte-serial MEM-stage data sequencer.
package mem_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_RSVD  = 2'd3
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Reserved size behaves as a word.
  function automatic logic [2:0] size_beats(
    input logic [1:0] size
  );
    logic [2:0] n;
    unique case (1'b1)
      size == SZ_BYTE: n = 3'd1;
      size == SZ_HALF: n = 3'd2;
      default:         n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic is_aligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic ok;
    unique case (1'b1)
      size == SZ_BYTE: ok = 1'b1;
      size == SZ_HALF: ok = ~lo[0];
      default:         ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_rdata_ext.sv
// mem_rdata_ext: sign/zero extension of an assembled load word.
// Ports: size, is_unsigned, raw (32b) -> result (32b), combinational.
module mem_rdata_ext
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  logic sb, sh;

  assign sb = ~is_unsigned & raw[7];
  assign sh = ~is_unsigned & raw[15];

  always_comb begin
    result = raw;
    unique case (1'b1)
      size == SZ_BYTE: result = {{24{sb}}, raw[7:0]};
      size == SZ_HALF: result = {{16{sh}}, raw[15:0]};
      default:         result = raw;
    endcase
  end

endmodule

// File: rtl/mem_data_seq.sv
// mem_data_seq: splits MEM-stage loads/stores into byte bus beats.
// Ports: ID op/size -> cycle count; MEM req/resp; 8-bit bus master.
module mem_data_seq
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_id_mem_op,
  input  logic [1:0]       i_id_size,
  output logic [3:0]       o_mem_data_access,
  input  logic             i_mem_req,
  input  logic             i_mem_we,
  input  logic [1:0]       i_mem_size,
  input  logic             i_mem_unsigned,
  input  logic [31:0]      i_mem_addr,
  input  logic [31:0]      i_mem_wdata,
  output logic [31:0]      o_mem_rdata,
  output logic             o_mem_done,
  output logic             o_mem_misalign,
  output logic             o_mem_busy,
  output logic             o_bus_en,
  output logic             o_bus_we,
  output logic [31:0]      o_bus_addr,
  output logic [BUS_W-1:0] o_bus_wdata,
  input  logic [BUS_W-1:0] i_bus_rdata
);

  mem_state_e  state_q, state_d;
  mem_req_t    req_q;
  logic [2:0]  beat_q;
  logic        mis_q;
  logic [31:0] raw_q;
  logic [31:0] raw_fill;
  logic [31:0] ext_res;
  logic [31:0] hold_q;
  logic [2:0]  n_beats;
  logic [1:0]  lane_prev;
  logic        last_beat;
  logic        req_ok;
  logic        load_done;
  logic        id_op;

  assign id_op = (i_id_mem_op == OP_LOAD)
              || (i_id_mem_op == OP_STORE);

  assign o_mem_data_access = id_op
    ? {1'b0, size_beats(i_id_size)} + 4'd1
    : 4'd0;

  assign n_beats   = size_beats(req_q.size);
  assign last_beat = (beat_q == n_beats - 3'd1);
  assign req_ok    = is_aligned(i_mem_size, i_mem_addr[1:0]);
  assign lane_prev = beat_q[1:0] - 2'd1;
  assign load_done = (state_q == ST_DONE)
                  && !mis_q && !req_q.we;

  // The final read byte arrives during DONE, so it is merged
  // straight from the bus rather than waiting another cycle.
  always_comb begin
    raw_fill = raw_q;
    raw_fill[{beat_q[1:0], 3'b000} +: BUS_W] = i_bus_rdata;
  end

  mem_rdata_ext u_ext (
    .size        (req_q.size),
    .is_unsigned (req_q.uns),
    .raw         (raw_fill),
    .result      (ext_res)
  );

  assign o_mem_rdata = load_done ? ext_res : hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_mem_req)
          state_d = req_ok ? ST_XFER : ST_DONE;
      end
      ST_XFER: begin
        if (last_beat) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_bus_en       = 1'b0;
    o_bus_we       = 1'b0;
    o_bus_addr     = '0;
    o_bus_wdata    = '0;
    o_mem_done     = 1'b0;
    o_mem_misalign = 1'b0;
    o_mem_busy     = 1'b0;
    unique case (state_q)
      ST_XFER: begin
        o_bus_en   = 1'b1;
        o_bus_we   = req_q.we;
        o_bus_addr = req_q.addr + {29'd0, beat_q};
        if (req_q.we)
          o_bus_wdata =
            req_q.wdata[{beat_q[1:0], 3'b000} +: BUS_W];
        o_mem_busy = 1'b1;
      end
      ST_DONE: begin
        o_mem_done     = 1'b1;
        o_mem_misalign = mis_q;
        o_mem_busy     = 1'b1;
      end
      default: ;
    endcase
  end

  // A misaligned request leaves req_q untouched so the held
  // load result and its extension stay as they were.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q  <= '0;
      beat_q <= '0;
      mis_q  <= 1'b0;
      raw_q  <= '0;
      hold_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_mem_req) begin
            mis_q <= !req_ok;
            if (req_ok) begin
              req_q <= '{
                we:    i_mem_we,
                size:  i_mem_size,
                uns:   i_mem_unsigned,
                addr:  i_mem_addr,
                wdata: i_mem_wdata
              };
              beat_q <= '0;
            end
          end
        end
        ST_XFER: begin
          if (!last_beat) beat_q <= beat_q + 3'd1;
          if (!req_q.we && beat_q != 3'd0)
            raw_q[{lane_prev, 3'b000} +: BUS_W] <= i_bus_rdata;
        end
        ST_DONE: begin
          if (load_done) hold_q <= ext_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_seq.sv
// tb_mem_data_seq: randomized and directed checks of mem_data_seq
// against a byte-array memory model and arithmetic load model.
module tb_mem_data_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  i_id_mem_op = '0;
  logic [1:0]  i_id_size = '0;
  logic [3:0]  o_mem_data_access;
  logic        i_mem_req = 1'b0;
  logic        i_mem_we = 1'b0;
  logic [1:0]  i_mem_size = '0;
  logic        i_mem_unsigned = 1'b0;
  logic [31:0] i_mem_addr = '0;
  logic [31:0] i_mem_wdata = '0;
  logic [31:0] o_mem_rdata;
  logic        o_mem_done;
  logic        o_mem_misalign;
  logic        o_mem_busy;
  logic        o_bus_en;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [7:0]  o_bus_wdata;
  logic [7:0]  i_bus_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem     [4096];
  logic [7:0]  ref_mem [4096];
  logic [31:0] exp_hold = '0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  data;
  } bus_t;

  bus_t blog[$];

  always #5 clk = ~clk;

  mem_data_seq dut (
    .clk               (clk),
    .rst               (rst),
    .i_id_mem_op       (i_id_mem_op),
    .i_id_size         (i_id_size),
    .o_mem_data_access (o_mem_data_access),
    .i_mem_req         (i_mem_req),
    .i_mem_we          (i_mem_we),
    .i_mem_size        (i_mem_size),
    .i_mem_unsigned    (i_mem_unsigned),
    .i_mem_addr        (i_mem_addr),
    .i_mem_wdata       (i_mem_wdata),
    .o_mem_rdata       (o_mem_rdata),
    .o_mem_done        (o_mem_done),
    .o_mem_misalign    (o_mem_misalign),
    .o_mem_busy        (o_mem_busy),
    .o_bus_en          (o_bus_en),
    .o_bus_we          (o_bus_we),
    .o_bus_addr        (o_bus_addr),
    .o_bus_wdata       (o_bus_wdata),
    .i_bus_rdata       (i_bus_rdata)
  );

  // Byte memory: samples the bus mid-cycle, answers reads in the
  // following cycle and drives junk when no read is pending.
  logic        pend;
  logic [31:0] paddr;
  always begin
    @(negedge clk);
    pend  = o_bus_en && !o_bus_we;
    paddr = o_bus_addr;
    if (o_bus_en) begin
      blog.push_back('{we: o_bus_we, addr: o_bus_addr,
                       data: o_bus_wdata});
      if (o_bus_we) mem[o_bus_addr[11:0]] = o_bus_wdata;
    end
    @(posedge clk);
    #1;
    i_bus_rdata = pend ? mem[paddr[11:0]] : 8'($urandom);
  end

  function automatic int m_beats(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_aligned(
    input logic [1:0] s, input logic [31:0] a);
    return (a % 32'(m_beats(s))) == 0;
  endfunction

  function automatic logic [31:0] m_load(
    input logic [1:0] s, input logic u, input logic [31:0] a);
    longint      v;
    int          n;
    logic [31:0] ai;
    v = 0;
    n = m_beats(s);
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v  = v + (longint'(ref_mem[ai[11:0]]) << (8 * i));
    end
    if (n < 4 && !u && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic run_req(
    input  bit          now,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output int          lat,
    output logic [31:0] rdata,
    output logic        mis,
    output logic        busy_ok
  );
    if (!now) @(negedge clk);
    blog.delete();
    i_mem_req      = 1'b1;
    i_mem_we       = we;
    i_mem_size     = size;
    i_mem_unsigned = uns;
    i_mem_addr     = addr;
    i_mem_wdata    = wdata;
    lat     = 0;
    rdata   = '0;
    mis     = 1'b0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!o_mem_busy) busy_ok = 1'b0;
      if (o_mem_done) begin
        rdata = o_mem_rdata;
        mis   = o_mem_misalign;
      end else begin
        i_mem_req      = 1'($urandom);
        i_mem_we       = 1'($urandom);
        i_mem_size     = 2'($urandom);
        i_mem_unsigned = 1'($urandom);
        i_mem_addr     = $urandom;
        i_mem_wdata    = $urandom;
      end
    end while (!o_mem_done && lat < 20);
    i_mem_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_mem_done, o_mem_misalign, o_mem_busy,
         o_bus_en, o_bus_we} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_flags got %b want 00000",
        {o_mem_done, o_mem_misalign, o_mem_busy,
         o_bus_en, o_bus_we});
    end
    n_cmp++;
    if (o_bus_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_addr got %h want 0", o_bus_addr);
    end
    n_cmp++;
    if (o_bus_wdata !== 8'h0) begin
      n_bad++;
      $display("FAIL rst_wdata got %h want 0", o_bus_wdata);
    end
    n_cmp++;
    if (o_mem_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_rdata got %h want 0", o_mem_rdata);
    end
    rst = 1'b1;
    exp_hold = '0;
    @(negedge clk);
    n_cmp++;
    if ({o_mem_busy, o_bus_en} !== 2'b0) begin
      n_bad++;
      $display("FAIL rst_idle got %b want 00",
        {o_mem_busy, o_bus_en});
    end
  endtask

  task automatic test_id_access();
    logic [1:0] t_op [6] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd2};
    logic [1:0] t_sz [6] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1};
    logic [3:0] t_ex [6] = '{4'd5, 4'd0, 4'd2, 4'd0, 4'd5, 4'd3};
    logic [3:0] ex;
    for (int i = 0; i < 6; i++) begin
      i_id_mem_op = t_op[i];
      i_id_size   = t_sz[i];
      #1;
      n_cmp++;
      if (o_mem_data_access !== t_ex[i]) begin
        n_bad++;
        $display("FAIL id_dir op=%0d sz=%0d got %0d want %0d",
          t_op[i], t_sz[i], o_mem_data_access, t_ex[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      i_id_mem_op = 2'($urandom);
      i_id_size   = 2'($urandom);
      ex = (i_id_mem_op == 2'd1 || i_id_mem_op == 2'd2)
         ? 4'(m_beats(i_id_size) + 1) : 4'd0;
      #1;
      n_cmp++;
      if (o_mem_data_access !== ex) begin
        n_bad++;
        $display("FAIL id_rnd op=%0d sz=%0d got %0d want %0d",
          i_id_mem_op, i_id_size, o_mem_data_access, ex);
      end
    end
    i_id_mem_op = '0;
    i_id_size   = '0;
  endtask

  task automatic test_word_load();
    logic [7:0]  b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int          lat;
    logic [31:0] rd;
    logic        mis, bok;
    for (int i = 0; i < 4; i++) begin
      mem[12'h100 + 12'(i)]     = b[i];
      ref_mem[12'h100 + 12'(i)] = b[i];
    end
    run_req(0, 1'b0, 2'd2, 1'b0, 32'h100, $urandom,
            lat, rd, mis, bok);
    n_cmp++;
    if (lat !== 5) begin
      n_bad++;
      $display("FAIL wl_lat got %0d want 5", lat);
    end
    n_cmp++;
    if (rd !== 32'h44332211) begin
      n_bad++;
      $display("FAIL wl_rdata got %h want 44332211", rd);
    end
    n_cmp++;
    if ({mis, bok} !== 2'b01) begin
      n_bad++;
      $display("FAIL wl_flags got %b want 01", {mis, bok});
    end
    n_cmp++;
    if (blog.size() !== 4) begin
      n_bad++;
      $display("FAIL wl_beats got %0d want 4", blog.size());
    end
    for (int i = 0; i < blog.size() && i < 4; i++) begin
      n_cmp++;
      if (blog[i] !== {1'b0, 32'h100 + 32'(i), 8'h00}) begin
        n_bad++;
        $display("FAIL wl_bus%0d got %h want %h", i, blog[i],
          {1'b0, 32'h100 + 32'(i), 8'h00});
      end
    end
    exp_hold = 32'h44332211;
  endtask

  task automatic test_byte_ext();
    int          lat;
    logic [31:0] rd, ex;
    logic        mis, bok;
    mem[12'h203]     = 8'h80;
    ref_mem[12'h203] = 8'h80;
    for (int u = 0; u < 2; u++) begin
      ex = (u == 0) ? 32'hFFFFFF80 : 32'h00000080;
      run_req(0, 1'b0, 2'd0, 1'(u), 32'h203, $urandom,
              lat, rd, mis, bok);
      n_cmp++;
      if (rd !== ex) begin
        n_bad++;
        $display("FAIL be_rdata u=%0d got %h want %h", u, rd, ex);
      end
      n_cmp++;
      if (lat !== 2) begin
        n_bad++;
        $display("FAIL be_lat u=%0d got %0d want 2", u, lat);
      end
      exp_hold = ex;
    end
  endtask

  task automatic test_half_store();
    int          lat;
    logic [31:0] rd;
    logic        mis, bok;
    bus_t        eb [2];
    eb[0] = '{we: 1'b1, addr: 32'h10, data: 8'hEF};
    eb[1] = '{we: 1'b1, addr: 32'h11, data: 8'hBE};
    run_req(0, 1'b1, 2'd1, 1'b0, 32'h10, 32'h1234BEEF,
            lat, rd, mis, bok);
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL hs_lat got %0d want 3", lat);
    end
    n_cmp++;
    if (blog.size() !== 2) begin
      n_bad++;
      $display("FAIL hs_beats got %0d want 2", blog.size());
    end
    for (int i = 0; i < blog.size() && i < 2; i++) begin
      n_cmp++;
      if (blog[i] !== eb[i]) begin
        n_bad++;
        $display("FAIL hs_bus%0d got %h want %h",
          i, blog[i], eb[i]);
      end
    end
    n_cmp++;
    if (rd !== exp_hold) begin
      n_bad++;
      $display("FAIL hs_rdata got %h want %h", rd, exp_hold);
    end
    ref_mem[12'h010] = 8'hEF;
    ref_mem[12'h011] = 8'hBE;
    run_req(0, 1'b0, 2'd1, 1'b0, 32'h10, $urandom,
            lat, rd, mis, bok);
    n_cmp++;
    if (rd !== 32'hFFFFBEEF) begin
      n_bad++;
      $display("FAIL hs_readback got %h want ffffbeef", rd);
    end
    exp_hold = 32'hFFFFBEEF;
  endtask

  task automatic test_misalign();
    int          lat;
    logic [31:0] rd, a;
    logic [1:0]  sz;
    logic        mis, bok;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        a  = 32'h102;
        sz = 2'd2;
      end else begin
        sz = (k % 2 == 0) ? 2'd1 : 2'd2;
        a  = ($urandom & ~32'h3)
           | ((sz == 2'd1) ? 32'h1 : 32'($urandom_range(1, 3)));
      end
      run_req(0, 1'($urandom), sz, 1'($urandom), a, $urandom,
              lat, rd, mis, bok);
      n_cmp++;
      if ({lat == 1, mis} !== 2'b11) begin
        n_bad++;
        $display("FAIL ma_pulse a=%h got lat=%0d mis=%b want 1 1",
          a, lat, mis);
      end
      n_cmp++;
      if (blog.size() !== 0) begin
        n_bad++;
        $display("FAIL ma_bus a=%h got %0d beats want 0",
          a, blog.size());
      end
      n_cmp++;
      if (rd !== exp_hold) begin
        n_bad++;
        $display("FAIL ma_rdata a=%h got %h want %h",
          a, rd, exp_hold);
      end
    end
  endtask

  task automatic test_ignore_in_done();
    int          lat;
    logic [31:0] rd, a;
    logic        mis, bok;
    a = 32'h300 + 32'($urandom_range(0, 255));
    run_req(0, 1'b1, 2'd0, 1'b0, a, 32'h5A, lat, rd, mis, bok);
    ref_mem[a[11:0]] = 8'h5A;
    i_mem_req  = 1'b1;
    i_mem_we   = 1'b0;
    i_mem_size = 2'd0;
    i_mem_addr = a;
    @(negedge clk);
    i_mem_req = 1'b0;
    n_cmp++;
    if ({o_mem_busy, o_bus_en} !== 2'b00) begin
      n_bad++;
      $display("FAIL done_ign got %b want 00",
        {o_mem_busy, o_bus_en});
    end
  endtask

  task automatic test_random(input int count);
    logic        we, uns, mis, bok;
    logic [1:0]  sz;
    logic [31:0] a, wd, rd, er, sh, ai;
    int          lat, n, el, eb;
    bit          al;
    bus_t        ex;
    for (int k = 0; k < count; k++) begin
      we  = 1'($urandom);
      sz  = 2'($urandom);
      uns = 1'($urandom);
      wd  = $urandom;
      a   = $urandom;
      n   = m_beats(sz);
      if ($urandom_range(0, 3) != 0) a = a - (a % 32'(n));
      al = m_aligned(sz, a);
      er = (al && !we) ? m_load(sz, uns, a) : exp_hold;
      el = al ? n + 1 : 1;
      eb = al ? n : 0;
      run_req(0, we, sz, uns, a, wd, lat, rd, mis, bok);
      n_cmp++;
      if (lat !== el) begin
        n_bad++;
        $display("FAIL rnd_lat k=%0d got %0d want %0d", k, lat, el);
      end
      n_cmp++;
      if ({mis, bok} !== {!al, 1'b1}) begin
        n_bad++;
        $display("FAIL rnd_flags k=%0d got %b want %b",
          k, {mis, bok}, {!al, 1'b1});
      end
      n_cmp++;
      if (rd !== er) begin
        n_bad++;
        $display("FAIL rnd_rdata k=%0d got %h want %h", k, rd, er);
      end
      n_cmp++;
      if (blog.size() !== eb) begin
        n_bad++;
        $display("FAIL rnd_beats k=%0d got %0d want %0d",
          k, blog.size(), eb);
      end
      for (int i = 0; i < blog.size() && i < eb; i++) begin
        sh = wd >> (8 * i);
        ex = '{we: we, addr: a + 32'(i),
               data: we ? sh[7:0] : 8'h00};
        n_cmp++;
        if (blog[i] !== ex) begin
          n_bad++;
          $display("FAIL rnd_bus k=%0d i=%0d got %h want %h",
            k, i, blog[i], ex);
        end
      end
      if (al && we) begin
        for (int i = 0; i < n; i++) begin
          sh = wd >> (8 * i);
          ai = a + 32'(i);
          ref_mem[ai[11:0]] = sh[7:0];
        end
      end
      if (al && !we) exp_hold = er;
    end
  endtask

  task automatic test_reset_abort();
    int          lat;
    logic [31:0] rd, a, er;
    logic        mis, bok, u;
    @(negedge clk);
    i_mem_req   = 1'b1;
    i_mem_we    = 1'b1;
    i_mem_size  = 2'd2;
    i_mem_addr  = 32'h800;
    i_mem_wdata = $urandom;
    @(negedge clk);
    i_mem_req = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_bus_en, o_bus_addr} !== {1'b1, 32'h802}) begin
      n_bad++;
      $display("FAIL ra_beat2 got en=%b a=%h want 1 802",
        o_bus_en, o_bus_addr);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({o_bus_en, o_mem_busy, o_mem_done} !== 3'b000) begin
      n_bad++;
      $display("FAIL ra_async got %b want 000",
        {o_bus_en, o_mem_busy, o_mem_done});
    end
    n_cmp++;
    if ({o_bus_addr, o_mem_rdata} !== 64'h0) begin
      n_bad++;
      $display("FAIL ra_clear got a=%h rd=%h want 0 0",
        o_bus_addr, o_mem_rdata);
    end
    exp_hold = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_mem_done, o_bus_en} !== 2'b00) begin
        n_bad++;
        $display("FAIL ra_quiet c=%0d got %b want 00",
          i, {o_mem_done, o_bus_en});
      end
    end
    rst = 1'b1;
    a  = 32'h40 + 32'($urandom_range(0, 63));
    u  = 1'($urandom);
    er = m_load(2'd0, u, a);
    run_req(1, 1'b0, 2'd0, u, a, $urandom, lat, rd, mis, bok);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL ra_first_lat got %0d want 2", lat);
    end
    n_cmp++;
    if (rd !== er) begin
      n_bad++;
      $display("FAIL ra_first_rdata got %h want %h", rd, er);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_id_access();
    test_word_load();
    test_byte_ext();
    test_half_store();
    test_misalign();
    test_ignore_in_done();
    test_random(60);
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
